mdio_master: RTL
================

// Module: mdio_master
// PURPOSE
//  - Clause-22 MDIO management master; generates MDC and drives/releases MDIO through the
//    tristate pad wrapper via mdio_o/mdio_t/mdio_i (mdio_t=1 releases the pad to high-Z).
//  - Used by the PHY-control path to read and write Ethernet PHY registers.
//  - Executes one 64-bit frame per accepted request: 32-bit preamble, ST, OP, PHYAD, REGAD, TA, DATA.
// PARAMETERS
//  - C_CLK_DIV      50  clk cycles per MDC half-period; MDC = f(clk)/(2*C_CLK_DIV); legal range >= 3
//  - C_PREAMBLE_LEN 32  number of preamble '1' bits; legal range 0..32
// PORTS
//  - clk        in   1   single clock; all logic is in this domain
//  - rst_n      in   1   asynchronous, active-low reset
//  - req_valid  in   1   request present
//  - req_ready  out  1   master idle; a request is accepted when req_valid && req_ready
//  - req_write  in   1   1 = write (OP=01), 0 = read (OP=10)
//  - req_phy    in   5   PHY address
//  - req_reg    in   5   register address
//  - req_data   in   16  write data; ignored on reads
//  - rsp_valid  out  1   one-clk pulse at frame end, for both reads and writes
//  - rsp_data   out  16  read data; holds its value until the next read completes
//  - mdc        out  1   management clock
//  - mdio_o     out  1   pad output value
//  - mdio_t     out  1   pad tristate control; 1 = high-Z
//  - mdio_i     in   1   pad input value
// BEHAVIOUR
//  - Reset values: mdc=0, mdio_o=1, mdio_t=1, rsp_valid=0, rsp_data=0, state=IDLE.
//    The async reset mid-frame aborts the frame immediately and the pad is released at once.
//  - req_ready = (state==IDLE). req_ready is 1 while the block is held in reset.
//  - IDLE: mdc is held at 0.
//  - Request accept, same cycle: latch all req_* fields; load the divider; drive the first frame bit.
//    The first frame bit is mdio_t=0 with mdio_o = first preamble bit, or ST[1]=0 if C_PREAMBLE_LEN=0.
//  - Divider: counts 0..C_CLK_DIV-1. On the terminal count, mdc toggles.
//  - mdc 0->1 (rise): sample mdio_i into the read shift register during the DATA state only.
//  - mdc 1->0 (fall): advance to the next bit and update mdio_o/mdio_t.
//  - First mdc rise occurs C_CLK_DIV clks after accept.
//  - FSM states, each advancing on the fall edge:
//    - IDLE -> PRE: C_PREAMBLE_LEN ones. Skipped if C_PREAMBLE_LEN=0.
//    - HDR: 14 bits, MSB first: ST=01, OP, PHYAD, REGAD.
//    - TA: 2 bits.
//      - Write: drive 1,0.
//      - Read: mdio_t=1 for both bits; mdio_i is not sampled.
//    - DATA: 16 bits, MSB first.
//      - Write: mdio_o = data bit.
//      - Read: mdio_t stays 1; a sample is taken on each rise.
//    - DONE: on the fall after the 16th data rise:
//      - mdio_t=1, mdio_o=1, mdc=0;
//      - rsp_data <= shift register (reads only); rsp_valid=1 for one clk;
//      - state -> IDLE. req_ready rises in the next clk.
//  - Frame length, C_PREAMBLE_LEN=32: 64 MDC periods = 64*2*C_CLK_DIV clks from accept to rsp_valid.
//  - req_valid while busy: ignored, with no stall side effects. req_* inputs may change once accepted.
//  - Back-to-back: a request presented in the first IDLE cycle is accepted. MDC stays low at least
//    C_CLK_DIV clks between frames.
// CONFIGURATION
//  - `MDIO_INPUT_SYNC_EN defined:
//    - mdio_i passes through a 2-flop synchronizer before sampling.
//    - The sample point moves to 2 clks after the mdc rise; this requires C_CLK_DIV >= 3.
//  - `MDIO_INPUT_SYNC_EN undefined:
//    - mdio_i is registered once, on the clk edge where mdc rises.
//    - The synchronizer flops are not instantiated.
// STRUCTURE
//  - Package mdio_pkg contains:
//    - state enum (IDLE, PRE, HDR, TA, DATA, DONE);
//    - MDIO_ST=2'b01, MDIO_OP_WR=2'b01, MDIO_OP_RD=2'b10;
//    - bit-count constants HDR_BITS=14, TA_BITS=2, DATA_BITS=16.
//  - Sub-module mdio_clk_div: counter that emits one-clk rise_tick and fall_tick strobes, and mdc.
//    Parameter C_CLK_DIV; inputs run and restart.
//  - Top module: FSM, shift registers, pad control, optional synchronizer.
// TESTING
//  - Setup: C_CLK_DIV=4; a PHY model on the pad drives mdio_i only while mdio_t=1 in TA/DATA.
//  1. Write phy=5'h01 reg=5'h00 data=16'h1140. Required:
//     - serial stream = 32x'1', 01, 01, 00001, 00000, 10, 0001000101000000;
//     - rsp_valid exactly 512 clks after accept; req_ready=0 throughout the frame.
//  2. Read phy=5'h03 reg=5'h02; model returns 16'h0141. Required:
//     - mdio_t=1 from the first TA bit to the end of the frame;
//     - rsp_data=16'h0141 when rsp_valid pulses.
//  3. Hold req_valid high with new fields during a frame. Required:
//     - second request accepted only in the first IDLE cycle;
//     - first frame bits unchanged.
//  4. Assert rst_n=0 mid-DATA of a read, then release. Required:
//     - mdc=0, mdio_t=1, rsp_valid=0 immediately;
//     - a new read completes correctly.
//  5. C_PREAMBLE_LEN=0. Required: frame is 32 MDC periods; first bit driven is 0 (ST).
//  6. Build with `MDIO_INPUT_SYNC_EN and repeat test 2. Required: identical rsp_data and frame timing.

Source files
------------

// File: rtl/mdio_pkg.sv
// -----------------------------------------------------------------------------
// mdio_pkg
//   Shared types and constants for the clause-22 MDIO master.
//   - state_t      : frame sequencer states
//   - MDIO_ST/OP_* : start-of-frame and opcode field values
//   - *_BITS       : per-field bit counts of the serial frame
// -----------------------------------------------------------------------------
package mdio_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      HDR,
      TA,
      DATA,
      DONE
   } state_t;

   localparam logic [1:0] MDIO_ST    = 2'b01;
   localparam logic [1:0] MDIO_OP_WR = 2'b01;
   localparam logic [1:0] MDIO_OP_RD = 2'b10;

   localparam int HDR_BITS  = 14;
   localparam int TA_BITS   = 2;
   localparam int DATA_BITS = 16;

endpackage

// File: rtl/mdio_clk_div.sv
// -----------------------------------------------------------------------------
// mdio_clk_div
//   MDC generator. A counter runs 0..C_CLK_DIV-1 while 'run' is high; each
//   terminal count toggles mdc. rise_tick/fall_tick are one-clk strobes that
//   are high in the cycle whose closing clk edge makes mdc rise/fall, so the
//   owner can act on exactly the same edge as the pin changes.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     run          : frame in progress; when low mdc is parked at 0
//     restart      : reload the counter (frame accept)
//     mdc          : management clock output
//     rise_tick    : mdc 0->1 on the coming edge
//     fall_tick    : mdc 1->0 on the coming edge
// -----------------------------------------------------------------------------
module mdio_clk_div #(
   parameter int C_CLK_DIV = 50
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic restart,
   output logic mdc,
   output logic rise_tick,
   output logic fall_tick
);

   localparam int            CW = (C_CLK_DIV > 1) ? $clog2(C_CLK_DIV) : 1;
   localparam logic [CW-1:0] TC = CW'(C_CLK_DIV - 1);

   logic [CW-1:0] cnt;
   logic          tc;

   assign tc        = run && !restart && (cnt == TC);
   assign rise_tick = tc && !mdc;
   assign fall_tick = tc && mdc;

   // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         mdc <= 1'b0;
      end else if (restart || !run) begin
         cnt <= '0;
         mdc <= 1'b0;
      end else if (tc) begin
         cnt <= '0;
         mdc <= ~mdc;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/mdio_master.sv
// -----------------------------------------------------------------------------
// mdio_master
//   Clause-22 MDIO management master. One accepted request produces one frame:
//   preamble (C_PREAMBLE_LEN ones), ST, OP, PHYAD, REGAD, TA, DATA. Bits change
//   on MDC falling edges; read data is sampled on MDC rising edges.
//   Optional build macro: MDIO_INPUT_SYNC_EN -- adds a 2-flop synchronizer on
//   mdio_i and moves the sample point 2 clks after the MDC rise (C_CLK_DIV>=3).
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     req_valid/req_ready   : request handshake; ready only in IDLE
//     req_write             : 1 = write, 0 = read
//     req_phy, req_reg      : PHY / register address
//     req_data              : write data (ignored on reads)
//     rsp_valid             : one-clk pulse at frame end
//     rsp_data              : last read data, held until the next read ends
//     mdc                   : management clock
//     mdio_o, mdio_t, mdio_i: pad output, tristate (1 = high-Z), pad input
// -----------------------------------------------------------------------------
module mdio_master
   import mdio_pkg::*;
#(
   parameter int C_CLK_DIV      = 50,
   parameter int C_PREAMBLE_LEN = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [4:0]  req_phy,
   input  logic [4:0]  req_reg,
   input  logic [15:0] req_data,
   output logic        rsp_valid,
   output logic [15:0] rsp_data,
   output logic        mdc,
   output logic        mdio_o,
   output logic        mdio_t,
   input  logic        mdio_i
);

   localparam logic [4:0] PRE_LAST  = (C_PREAMBLE_LEN > 0) ? 5'(C_PREAMBLE_LEN - 1) : 5'd0;
   localparam logic [4:0] HDR_LAST  = 5'(HDR_BITS - 1);
   localparam logic [4:0] TA_LAST   = 5'(TA_BITS - 1);
   localparam logic [4:0] DATA_LAST = 5'(DATA_BITS - 1);

   state_t      state, state_nxt;
   logic [4:0]  bit_cnt, bit_nxt;      // remaining bits in the current field, minus one
   logic [31:0] tx_shift, tx_nxt;      // ST..DATA, current bit at [31]
   logic [15:0] rx_shift, rx_nxt;
   logic        is_read, rd_nxt;
   logic        mdio_o_nxt, mdio_t_nxt, rsp_valid_nxt;
   logic [15:0] rsp_data_nxt;
   logic        accept, run;
   logic        rise_tick, fall_tick;
   logic        sample_tick, sample_bit;

   assign req_ready = (state == IDLE);
   assign accept    = req_valid && req_ready;
   assign run       = (state == PRE) || (state == HDR) || (state == TA) || (state == DATA);

   mdio_clk_div #(
      .C_CLK_DIV (C_CLK_DIV)
   ) u_clk_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .restart   (accept),
      .mdc       (mdc),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick)
   );

`ifdef MDIO_INPUT_SYNC_EN
   // Synchronize the pad input; the rise strobe is delayed by the same two
   // clks so the sample lands on the bit that was on the pin at the rise.
   logic [1:0] sync_q;
   logic [1:0] rise_dly;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= 2'b11;
         rise_dly <= 2'b00;
      end else begin
         sync_q   <= {sync_q[0], mdio_i};
         rise_dly <= {rise_dly[0], rise_tick};
      end
   end

   assign sample_tick = rise_dly[1];
   assign sample_bit  = sync_q[1];
`else
   assign sample_tick = rise_tick;
   assign sample_bit  = mdio_i;
`endif

   always_comb begin
      // NOTE: every next value starts from its hold value, so no path can infer a latch.
      state_nxt     = state;
      bit_nxt       = bit_cnt;
      tx_nxt        = tx_shift;
      rx_nxt        = rx_shift;
      rd_nxt        = is_read;
      mdio_o_nxt    = mdio_o;
      mdio_t_nxt    = mdio_t;
      rsp_valid_nxt = 1'b0;
      rsp_data_nxt  = rsp_data;

      if (sample_tick && (state == DATA) && is_read)
         rx_nxt = {rx_shift[14:0], sample_bit};

      case (state)
         IDLE: begin
            if (req_valid) begin
               rd_nxt     = !req_write;
               // Reads park the pad-output bits at 1; the pad is released anyway.
               tx_nxt     = {MDIO_ST, (req_write ? MDIO_OP_WR : MDIO_OP_RD), req_phy, req_reg,
                             (req_write ? {2'b10, req_data} : {2'b11, 16'hFFFF})};
               mdio_t_nxt = 1'b0;
               if (C_PREAMBLE_LEN > 0) begin
                  state_nxt  = PRE;
                  bit_nxt    = PRE_LAST;
                  mdio_o_nxt = 1'b1;
               end else begin
                  state_nxt  = HDR;
                  bit_nxt    = HDR_LAST;
                  mdio_o_nxt = MDIO_ST[1];
               end
            end
         end

         PRE: begin
            if (fall_tick) begin
               bit_nxt = bit_cnt - 5'd1;
               if (bit_cnt == 5'd0) begin
                  // Header starts with tx_shift[31]; nothing has been shifted yet.
                  state_nxt  = HDR;
                  bit_nxt    = HDR_LAST;
                  mdio_o_nxt = tx_shift[31];
               end
            end
         end

         HDR, TA, DATA: begin
            if (fall_tick) begin
               tx_nxt     = {tx_shift[30:0], 1'b1};
               mdio_o_nxt = tx_shift[30];
               bit_nxt    = bit_cnt - 5'd1;
               if (bit_cnt == 5'd0) begin
                  if (state == HDR) begin
                     state_nxt  = TA;
                     bit_nxt    = TA_LAST;
                     mdio_t_nxt = is_read;
                  end else if (state == TA) begin
                     state_nxt = DATA;
                     bit_nxt   = DATA_LAST;
                  end else begin
                     state_nxt     = DONE;
                     mdio_t_nxt    = 1'b1;
                     mdio_o_nxt    = 1'b1;
                     rsp_valid_nxt = 1'b1;
                     if (is_read)
                        rsp_data_nxt = rx_shift;
                  end
               end
            end
         end

         DONE: state_nxt = IDLE;

         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bit_cnt   <= 5'd0;
         tx_shift  <= '0;
         rx_shift  <= '0;
         is_read   <= 1'b0;
         mdio_o    <= 1'b1;
         mdio_t    <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         state     <= state_nxt;
         bit_cnt   <= bit_nxt;
         tx_shift  <= tx_nxt;
         rx_shift  <= rx_nxt;
         is_read   <= rd_nxt;
         mdio_o    <= mdio_o_nxt;
         mdio_t    <= mdio_t_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_data  <= rsp_data_nxt;
      end
   end

endmodule
